mat_mac_core: RTL
=================

Name: mat_mac_core

Overview:
- Downstream consumer of mat_deinterleave. Accepts the A and B matrix streams it produces, buffers one DIM x DIM matrix of each (row-major), computes C = A x B with a single sequential MAC, and emits C row-major on an AXI-stream master.
- Operates on one matrix pair per batch: LOAD, COMPUTE, OUTPUT, then back to LOAD.

Parameters:
- DIM, 2, matrix dimension (square); legal range 2..8.
- DATA_W, 8, element width of A and B (signed two's complement).
- ACC_W, 17, width of C elements. Must be >= 2*DATA_W + clog2(DIM); the default is exact for DATA_W=8, DIM=2.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- s_axis_a_data  in  DATA_W  A element, row-major.
- s_axis_a_valid  in  1  A element valid.
- s_axis_a_ready  out  1  A element accepted when valid && ready.
- s_axis_b_data  in  DATA_W  B element, row-major.
- s_axis_b_valid  in  1  B element valid.
- s_axis_b_ready  out  1  B element accepted when valid && ready.
- m_axis_c_data  out  ACC_W  C element, row-major, signed.
- m_axis_c_valid  out  1  C element valid.
- m_axis_c_ready  in  1  downstream accepts C.
- m_axis_c_last  out  1  high with valid on the final C element (index DIM*DIM-1).

Behaviour:
- Reset (i_rst_n low at an edge):
  - state=LOAD; A/B counts=0; row/col/k=0; acc=0.
  - Outputs: s_axis_a_ready=0, s_axis_b_ready=0 during reset, then 1 in LOAD; m_axis_c_valid=0, m_axis_c_last=0, m_axis_c_data=0.
  - Reset mid-operation discards all buffered and partial data; no C beat is emitted for the aborted batch.
- LOAD:
  - s_axis_a_ready = (a_cnt < DIM*DIM); s_axis_b_ready = (b_cnt < DIM*DIM). Both are registered or derived only from counts, never combinationally from the input valids.
  - Each handshake writes the element at index cnt and increments cnt.
  - A and B are independent: either may fill completely before the other starts. This is required, because the upstream block may serve only one stream at a time.
  - Once a stream is full its ready drops and its valid is ignored.
  - The edge that makes both counts DIM*DIM (E) moves the state to COMPUTE, with row=col=k=0 and acc=0.
- COMPUTE:
  - Readies are 0.
  - Each edge: acc <= acc + sext(A[row][k]) * sext(B[k][col]); k++.
  - The edge performing k=DIM-1 loads m_axis_c_data with the final sum, sets valid=1 and sets last=(row==DIM-1 && col==DIM-1). State -> OUTPUT.
  - First C valid is visible after edge E+DIM. Each subsequent element takes DIM compute cycles plus the handshake cycle.
- OUTPUT:
  - data, valid and last are held stable until m_axis_c_ready=1 at an edge.
  - On that handshake: valid=0 and last=0.
  - If it was the last element: state=LOAD, counts cleared, readies return to 1 on the next cycle.
  - Otherwise: advance col (wrap to 0, row++), acc=0, k=0, state=COMPUTE.
- Arithmetic:
  - Signed multiply; products and acc are sign-extended to ACC_W.
  - No saturation; with a legal ACC_W no overflow is possible.
- Simultaneous events:
  - A and B handshakes in the same cycle are both accepted.
  - m_axis_c_ready high while valid is low has no effect.
  - Input valid during COMPUTE or OUTPUT is not accepted and does not corrupt buffers.

Test Plan:
- Basic (DIM=2): A=[1,2,3,4], B=[5,6,7,8], both streams concurrent, c_ready held 1 -> C=[19,22,43,50]; last only on 50; first valid exactly 2 cycles after the last load edge.
- Serialised inputs: all 4 A beats with b_valid=0, then all 4 B beats; A=[-1,2,3,-4], B=[5,-6,7,8] -> C=[9,22,-13,-50]; a_ready drops after the 4th A beat while B is still pending.
- Extremes: all A and B = -128 -> every C = 32768 (17'h08000); no sign wrap.
- Backpressure: c_ready toggling 0/1 per cycle, per the toggled-ready pattern used on the upstream bench -> each C value is held unchanged while ready=0; no beat is lost or duplicated; readies stay 0 until the final C handshake.
- Back-to-back batches: second batch with A=identity, B=[9,8,7,6] presented immediately after the first batch's last handshake -> C=[9,8,7,6]; no residue from the first batch.
- Reset mid-COMPUTE and mid-OUTPUT: assert i_rst_n=0 for 1 cycle -> valid=0 and readies=0 during reset; readies=1 after; a fresh batch produces correct results.

Source files
------------

// File: rtl/mat_mac_core.sv
// Buffers one DIM x DIM pair of signed matrices from two AXI-stream inputs,
// computes C = A x B with one sequential MAC and streams C out row-major.
module mat_mac_core #(
  parameter int DIM    = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 17
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] s_axis_a_data,
  input  logic              s_axis_a_valid,
  output logic              s_axis_a_ready,
  input  logic [DATA_W-1:0] s_axis_b_data,
  input  logic              s_axis_b_valid,
  output logic              s_axis_b_ready,
  output logic [ACC_W-1:0]  m_axis_c_data,
  output logic              m_axis_c_valid,
  input  logic              m_axis_c_ready,
  output logic              m_axis_c_last
);

  localparam int N      = DIM * DIM;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int ADDR_W = $clog2(N);
  localparam int IDX_W  = $clog2(DIM);
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_OUTPUT} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d, k_q, k_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] a_mem_q [N];
  logic [DATA_W-1:0] a_mem_d [N];
  logic [DATA_W-1:0] b_mem_q [N];
  logic [DATA_W-1:0] b_mem_d [N];
  logic              a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic [ACC_W-1:0]  c_data_q, c_data_d;
  logic              c_valid_q, c_valid_d, c_last_q, c_last_d;

  logic                     a_hs, b_hs, c_hs, k_last, row_last, col_last;
  logic [ADDR_W-1:0]        a_addr, b_addr;
  logic signed [DATA_W-1:0] a_elem, b_elem;
  logic signed [PROD_W-1:0] prod;
  logic [ACC_W-1:0]         acc_sum;

  assign a_hs     = s_axis_a_valid && a_ready_q;
  assign b_hs     = s_axis_b_valid && b_ready_q;
  assign c_hs     = c_valid_q && m_axis_c_ready;
  assign k_last   = (k_q == IDX_W'(DIM - 1));
  assign row_last = (row_q == IDX_W'(DIM - 1));
  assign col_last = (col_q == IDX_W'(DIM - 1));

  assign a_addr  = ADDR_W'(int'(row_q) * DIM + int'(k_q));
  assign b_addr  = ADDR_W'(int'(k_q) * DIM + int'(col_q));
  assign a_elem  = a_mem_q[a_addr];
  assign b_elem  = b_mem_q[b_addr];
  assign prod    = a_elem * b_elem;
  assign acc_sum = acc_q + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= ST_LOAD;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      row_q     <= '0;
      col_q     <= '0;
      k_q       <= '0;
      acc_q     <= '0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      c_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      k_q       <= k_d;
      acc_q     <= acc_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
      c_last_q  <= c_last_d;
    end
  end

  // Buffer contents need no reset: counts gate every read and write.
  always_ff @(posedge i_clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD:    if (a_cnt_d == CNT_W'(N) && b_cnt_d == CNT_W'(N)) state_d = ST_COMPUTE;
      ST_COMPUTE: if (k_last) state_d = ST_OUTPUT;
      ST_OUTPUT:  if (c_hs) state_d = c_last_q ? ST_LOAD : ST_COMPUTE;
      default:    state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    a_cnt_d   = a_cnt_q;
    b_cnt_d   = b_cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    k_d       = k_q;
    acc_d     = acc_q;
    a_mem_d   = a_mem_q;
    b_mem_d   = b_mem_q;
    c_data_d  = c_data_q;
    c_valid_d = c_valid_q;
    c_last_d  = c_last_q;
    unique case (state_q)
      ST_LOAD: begin
        if (a_hs) begin
          a_mem_d[ADDR_W'(a_cnt_q)] = s_axis_a_data;
          a_cnt_d = a_cnt_q + 1'b1;
        end
        if (b_hs) begin
          b_mem_d[ADDR_W'(b_cnt_q)] = s_axis_b_data;
          b_cnt_d = b_cnt_q + 1'b1;
        end
        row_d = '0;
        col_d = '0;
        k_d   = '0;
        acc_d = '0;
      end
      ST_COMPUTE: begin
        acc_d = acc_sum;
        if (k_last) begin
          k_d       = '0;
          c_data_d  = acc_sum;
          c_valid_d = 1'b1;
          c_last_d  = row_last && col_last;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_OUTPUT: begin
        if (c_hs) begin
          c_valid_d = 1'b0;
          c_last_d  = 1'b0;
          acc_d     = '0;
          k_d       = '0;
          if (c_last_q) begin
            a_cnt_d = '0;
            b_cnt_d = '0;
            row_d   = '0;
            col_d   = '0;
          end else if (col_last) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Readies are registered from next-state and next-count, never from valids.
  always_comb begin
    a_ready_d = (state_d == ST_LOAD) && (a_cnt_d < CNT_W'(N));
    b_ready_d = (state_d == ST_LOAD) && (b_cnt_d < CNT_W'(N));
  end

  assign s_axis_a_ready = a_ready_q;
  assign s_axis_b_ready = b_ready_q;
  assign m_axis_c_data  = c_data_q;
  assign m_axis_c_valid = c_valid_q;
  assign m_axis_c_last  = c_last_q;

endmodule
